vlc_tx_scheduler: RTL and testbench
===================================

# vlc_tx_scheduler

Transmit controller for the VLC LED channel. Two requesters share one LED transmitter: requester 0 is the HPS command path and requester 1 is the switch-start path. The block arbitrates between them round-robin, fetches each granted frame's payload bytes over a byte-read handshake, and sends a Manchester-encoded frame (SYNC, LEN, payload) on the LED pin. It sits between the HPS/switch control logic and the GPIO conduit.

## Interface
- CLK_DIV, 25, clock cycles per half-bit (chip); legal range 1..1023
- SYNC, 8'hD5, start-of-frame byte
- GAP_BITS, 4, idle bit periods forced between frames; 0 allowed

- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- req  in  2  frame request per requester; level, held until done
- len0  in  8  payload byte count for requester 0, sampled at grant
- len1  in  8  payload byte count for requester 1, sampled at grant
- grant  out  2  one-hot owner of the transmitter; held for the whole frame
- rd_req  out  1  payload byte fetch request
- rd_sel  out  1  index of the requester whose buffer is being read
- rd_data  in  8  fetched payload byte
- rd_valid  in  1  rd_data valid; accepted only while rd_req=1
- led_out  out  1  Manchester chip stream; idle level 0
- busy  out  1  high from grant until the end of the inter-frame gap
- done  out  1  one-cycle pulse at frame end, including after an abort
- err  out  1  one-cycle pulse on payload underrun abort

## Operation
- States: IDLE, SYNC, LEN, DATA, [CRC], GAP.
- IDLE: on any req bit set, grant the winner. Ties go to the requester not granted last; the last-granted pointer resets to 1, so requester 0 wins first. Latch the winner's len into len_r, then go to SYNC.
- Bytes are sent MSB first. Bit 1 = low chip then high chip; bit 0 = high chip then low chip.
- SYNC: sends the SYNC byte, then LEN.
- LEN: sends len_r, then DATA if len_r≠0; otherwise CRC or end of frame.
- DATA: sends len_r payload bytes. A down-counter tracks remaining bytes.
- Prefetch: at the first cycle of LEN and of every payload byte except the last, raise rd_req to fetch the next payload byte.
  - rd_req stays high until the cycle in which rd_valid=1; rd_data is captured in that cycle and rd_req is low the next cycle.
  - rd_sel equals the granted index throughout the frame.
- Underrun: if the prefetched byte has not arrived by the byte boundary, abort.
  - led_out is 0 from that boundary; rd_req drops.
  - err and done pulse together; grant clears; go to GAP.
- End of frame: done pulses, grant clears, the pointer updates, then GAP.
- GAP: led_out=0 for GAP_BITS·2·CLK_DIV cycles, then IDLE. busy drops on entry to IDLE.
- req deasserting mid-frame is ignored; the frame completes. req asserted during GAP waits until IDLE.
- len values other than the latched len_r are ignored after grant.

## Timing
- Reset values: grant=0, rd_req=0, rd_sel=0, led_out=0, busy=0, done=0, err=0. Pointer=1; state=IDLE.
- Reset mid-frame forces all outputs to their reset values immediately (asynchronously).
- Req seen in IDLE at cycle N: grant, busy and the first SYNC chip appear at N+1.
- One bit lasts 2·CLK_DIV cycles; one byte lasts 16·CLK_DIV cycles.
- Frame length F = (2+len[+1])·16·CLK_DIV cycles. done is high at N+1+F, the first cycle after the last chip; grant is 0 that same cycle.
- Next grant: earliest at N+2+F+GAP_BITS·2·CLK_DIV.
- A fetch responded to with 0-cycle rd_valid latency (rd_valid high in the first rd_req cycle) is legal.

## Configuration
- VLC_CRC8_EN defined: a CRC state is inserted after DATA, or after LEN when len=0. It sends CRC-8 (poly 0x07, init 0x00, MSB first, no final XOR) computed over the LEN byte and the payload bytes. F includes the extra byte.
- VLC_CRC8_EN undefined: no CRC state, no CRC logic; the frame ends after the last payload byte.

## Test plan
- CLK_DIV=2, GAP_BITS=4, req=01, len0=1, rd_valid one cycle after rd_req with rd_data=0x3C -> chips decode to D5,01,3C; grant=01; done at N+1+96; err never asserted.
- req=11 right after reset, len0=len1=0 -> grant=01 for the first frame; after a 16-cycle gap, grant=10; each frame is 64 cycles.
- len0=0 -> rd_req never asserts; frame carries D5,00; done at N+1+64.
- len0=2, rd_valid withheld -> rd_req held high from the first LEN cycle; at the LEN→DATA boundary, err and done pulse together, led_out=0, grant=00.
- reset_n low for 1 cycle mid-payload -> every output reads 0 in that cycle; the first grant after release goes to requester 0.
- VLC_CRC8_EN defined, len0=1, rd_data=0x00 -> bytes D5,01,00,15; done at N+1+128.

Source files
------------

// File: rtl/vlc_tx_scheduler.sv
// vlc_tx_scheduler: round-robin transmit controller for the VLC LED channel.
// Two requesters (0 = HPS command path, 1 = switch-start path) share one LED
// transmitter. The granted frame is sent Manchester-encoded as SYNC, LEN,
// payload (and an optional CRC-8 byte), with payload bytes prefetched one
// byte ahead over a rd_req/rd_valid handshake.
//
// Optional feature macro: VLC_CRC8_EN appends a CRC-8 byte (poly 0x07,
// init 0x00) computed over LEN and the payload.
//
// Ports:
//   clk, reset_n    clock, asynchronous active-low reset
//   req[1:0]        level frame request per requester
//   len0, len1      payload byte count per requester, sampled at grant
//   grant[1:0]      one-hot transmitter owner for the whole frame
//   rd_req, rd_sel  payload byte fetch request and requester index
//   rd_data         fetched byte, accepted while rd_req and rd_valid are high
//   rd_valid        fetched byte valid
//   led_out         Manchester chip stream, idle 0
//   busy            high from grant until the inter-frame gap ends
//   done, err       frame-end pulse, underrun-abort pulse
module vlc_tx_scheduler #(
  parameter int unsigned CLK_DIV  = 25,
  parameter logic [7:0]  SYNC     = 8'hD5,
  parameter int unsigned GAP_BITS = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic [7:0] len0,
  input  logic [7:0] len1,
  output logic [1:0] grant,
  output logic       rd_req,
  output logic       rd_sel,
  input  logic [7:0] rd_data,
  input  logic       rd_valid,
  output logic       led_out,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned CNT_W    = 10;
  localparam int unsigned GAP_CYC  = GAP_BITS * 2 * CLK_DIV;
  localparam int unsigned GAP_LAST = (GAP_CYC == 0) ? 0 : GAP_CYC - 1;
  localparam int unsigned GAP_W    = $clog2(GAP_CYC + 2);

`ifdef VLC_CRC8_EN
  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_LEN, S_DATA, S_CRC, S_GAP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_LEN, S_DATA, S_GAP} state_t;
`endif

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;     // cycles within the current chip
  logic [3:0]         chip_q, chip_d;   // chip index within the current byte
  logic [7:0]         sh_q, sh_d;       // byte on the wire
  logic [7:0]         len_q, len_d;
  logic [7:0]         rem_q, rem_d;     // payload bytes left, including the one on the wire
  logic [7:0]         pf_q, pf_d;       // prefetched payload byte
  logic               pfv_q, pfv_d;
  logic               gidx_q, gidx_d;
  logic               ptr_q, ptr_d;     // last granted requester
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [1:0]         grant_d;
  logic               rd_req_d, rd_sel_d, led_d, busy_d, done_d, err_d;
  logic               win, fin, abort, last_cycle, byte_end, fetch_ok, tx_d;
  logic [7:0]         fetch_byte;
`ifdef VLC_CRC8_EN
  logic [7:0]         crc_q, crc_d;

  // CRC-8, poly 0x07, one byte per call
  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction
`endif

  // Manchester chip: bit 1 -> low,high; bit 0 -> high,low; MSB first
  function automatic logic chip_val(input logic [7:0] b, input logic [3:0] idx);
    return ~(b[3'(3'd7 - idx[3:1])] ^ idx[0]);
  endfunction

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      chip_q  <= '0;
      sh_q    <= '0;
      len_q   <= '0;
      rem_q   <= '0;
      pf_q    <= '0;
      pfv_q   <= 1'b0;
      gidx_q  <= 1'b0;
      ptr_q   <= 1'b1;
      gap_q   <= '0;
      grant   <= '0;
      rd_req  <= 1'b0;
      rd_sel  <= 1'b0;
      led_out <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
`ifdef VLC_CRC8_EN
      crc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      chip_q  <= chip_d;
      sh_q    <= sh_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      pf_q    <= pf_d;
      pfv_q   <= pfv_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      gap_q   <= gap_d;
      grant   <= grant_d;
      rd_req  <= rd_req_d;
      rd_sel  <= rd_sel_d;
      led_out <= led_d;
      busy    <= busy_d;
      done    <= done_d;
      err     <= err_d;
`ifdef VLC_CRC8_EN
      crc_q   <= crc_d;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    chip_d   = chip_q;
    sh_d     = sh_q;
    len_d    = len_q;
    rem_d    = rem_q;
    pf_d     = pf_q;
    pfv_d    = pfv_q;
    gidx_d   = gidx_q;
    ptr_d    = ptr_q;
    gap_d    = gap_q;
    grant_d  = grant;
    rd_req_d = rd_req;
    rd_sel_d = rd_sel;
    done_d   = 1'b0;
    err_d    = 1'b0;
    win      = 1'b0;
    fin      = 1'b0;
    abort    = 1'b0;
`ifdef VLC_CRC8_EN
    crc_d    = crc_q;
`endif

    last_cycle = (cnt_q == CNT_W'(CLK_DIV - 1));
    byte_end   = last_cycle && (chip_q == 4'd15);
    // A byte arriving in the boundary cycle itself still counts as on time
    fetch_ok   = pfv_q || (rd_req && rd_valid);
    fetch_byte = pfv_q ? pf_q : rd_data;

    if (rd_req && rd_valid) begin
      pf_d     = rd_data;
      pfv_d    = 1'b1;
      rd_req_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (|req) begin
          win      = (req == 2'b11) ? ~ptr_q : req[1];
          gidx_d   = win;
          grant_d  = win ? 2'b10 : 2'b01;
          rd_sel_d = win;
          len_d    = win ? len1 : len0;
          sh_d     = SYNC;
          cnt_d    = '0;
          chip_d   = '0;
          pfv_d    = 1'b0;
          state_d  = S_SYNC;
        end
      end
`ifdef VLC_CRC8_EN
      S_SYNC, S_LEN, S_DATA, S_CRC: begin
`else
      S_SYNC, S_LEN, S_DATA: begin
`endif
        if (last_cycle) begin
          cnt_d  = '0;
          chip_d = 4'(chip_q + 4'd1);
        end else begin
          cnt_d  = CNT_W'(cnt_q + 1'b1);
        end
        if (byte_end) begin
          case (state_q)
            S_SYNC: begin
              state_d  = S_LEN;
              sh_d     = len_q;
              rd_req_d = (len_q != 8'd0);
`ifdef VLC_CRC8_EN
              crc_d    = crc8(8'h00, len_q);
`endif
            end
            S_LEN, S_DATA: begin
              if ((state_q == S_LEN && len_q == 8'd0) || (state_q == S_DATA && rem_q == 8'd1)) begin
`ifdef VLC_CRC8_EN
                state_d = S_CRC;
                sh_d    = crc_q;
`else
                fin     = 1'b1;
`endif
              end else if (fetch_ok) begin
                // Load the next payload byte and prefetch the one after it
                state_d  = S_DATA;
                sh_d     = fetch_byte;
                rem_d    = (state_q == S_LEN) ? len_q : 8'(rem_q - 8'd1);
                pfv_d    = 1'b0;
                rd_req_d = (state_q == S_LEN) ? (len_q > 8'd1) : (rem_q > 8'd2);
`ifdef VLC_CRC8_EN
                crc_d    = crc8(crc_q, fetch_byte);
`endif
              end else begin
                abort = 1'b1;
              end
            end
            default: fin = 1'b1;
          endcase
        end
      end
      S_GAP: begin
        if (gap_q == GAP_W'(GAP_LAST)) state_d = S_IDLE;
        else gap_d = GAP_W'(gap_q + 1'b1);
      end
      default: state_d = S_IDLE;
    endcase

    // Frame end or underrun abort releases the transmitter
    if (fin || abort) begin
      grant_d  = '0;
      rd_req_d = 1'b0;
      rd_sel_d = 1'b0;
      done_d   = 1'b1;
      err_d    = abort;
      ptr_d    = gidx_q;
      pfv_d    = 1'b0;
      gap_d    = '0;
      state_d  = (GAP_CYC == 0) ? S_IDLE : S_GAP;
    end

    tx_d   = (state_d != S_IDLE) && (state_d != S_GAP);
    led_d  = tx_d ? chip_val(sh_d, chip_d) : 1'b0;
    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_vlc_tx_scheduler.sv
// Directed self-checking bench for vlc_tx_scheduler (CLK_DIV=2, GAP_BITS=4).
// Outputs are sampled on the falling edge; index 0 of each recording is the
// first cycle after the request is seen.
module tb_vlc_tx_scheduler;

  localparam int CD = 2;
  localparam int GB = 4;
  localparam int G  = GB * 2 * CD;
  localparam int BC = 16 * CD;
`ifdef VLC_CRC8_EN
  localparam int CN = 1;
`else
  localparam int CN = 0;
`endif

  logic       clk;
  logic       reset_n;
  logic [1:0] req;
  logic [7:0] len0, len1;
  logic [1:0] grant;
  logic       rd_req, rd_sel;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       led_out, busy, done, err;

  vlc_tx_scheduler #(.CLK_DIV(CD), .SYNC(8'hD5), .GAP_BITS(GB)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .len0(len0), .len1(len1),
    .grant(grant), .rd_req(rd_req), .rd_sel(rd_sel), .rd_data(rd_data),
    .rd_valid(rd_valid), .led_out(led_out), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic       led_a   [0:511];
  logic [1:0] grant_a [0:511];
  logic       done_a  [0:511];
  logic       err_a   [0:511];
  logic       rdreq_a [0:511];
  logic       rdsel_a [0:511];
  logic       busy_a  [0:511];
  int         n;
  logic       rdreq_any, err_any;

  // Byte-read responder: 0 = valid one cycle after rd_req, 1 = withhold, 2 = same cycle
  int         resp_mode = 0;
  logic [7:0] resp_byte = 8'h00;
  int         hold = 0;
  always @(negedge clk) begin
    if (rd_req && resp_mode != 1) begin
      rd_valid = (resp_mode == 2) || (hold >= 1);
      hold++;
    end else begin
      rd_valid = 1'b0;
      hold = 0;
    end
    rd_data = resp_byte;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic watch(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      led_a[n]   = led_out;
      grant_a[n] = grant;
      done_a[n]  = done;
      err_a[n]   = err;
      rdreq_a[n] = rd_req;
      rdsel_a[n] = rd_sel;
      busy_a[n]  = busy;
      if (rd_req === 1'b1) rdreq_any = 1'b1;
      if (err !== 1'b0) err_any = 1'b1;
      n++;
    end
  endtask

  // Decode one byte from recorded chips; the second chip of each bit is the bit value
  function automatic logic [7:0] dec(input int s);
    logic [7:0] r;
    for (int b = 0; b < 8; b++) r[7-b] = led_a[s + (2*b + 1)*CD];
    return r;
  endfunction

  function automatic logic [7:0] ref_crc(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    logic       fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[7] ^ d[i];
      r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return r;
  endfunction

  task automatic start(input logic [1:0] r);
    n = 0;
    rdreq_any = 1'b0;
    err_any = 1'b0;
    req = r;
  endtask

  int fa, fb;

  initial begin
    reset_n = 1'b1;
    req = 2'b00;
    len0 = 8'd0;
    len1 = 8'd0;
    rd_data = 8'h00;
    rd_valid = 1'b0;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_rd_req", 32'(rd_req), 32'h0);
    chk("rst_rd_sel", 32'(rd_sel), 32'h0);
    chk("rst_led", 32'(led_out), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Both requesters with len 0: requester 0 first, then 1 after the gap
    fa = (2 + CN) * BC;
    start(2'b11);
    watch(2*fa + G + 2);
    req = 2'b00;
    chk("a_grant0", 32'(grant_a[0]), 32'h1);
    chk("a_busy0", 32'(busy_a[0]), 32'h1);
    chk("a_sync", 32'(dec(0)), 32'hD5);
    chk("a_len", 32'(dec(BC)), 32'h00);
`ifdef VLC_CRC8_EN
    chk("a_crc", 32'(dec(2*BC)), 32'h00);
`endif
    chk("a_done_early", 32'(done_a[fa-1]), 32'h0);
    chk("a_done", 32'(done_a[fa]), 32'h1);
    chk("a_grant_end", 32'(grant_a[fa]), 32'h0);
    chk("a_busy_gap", 32'(busy_a[fa+G-1]), 32'h1);
    chk("a_busy_idle", 32'(busy_a[fa+G]), 32'h0);
    chk("a_grant_idle", 32'(grant_a[fa+G]), 32'h0);
    chk("a_grant1", 32'(grant_a[fa+G+1]), 32'h2);
    chk("a_rdsel1", 32'(rdsel_a[fa+G+1]), 32'h1);
    chk("a_sync2", 32'(dec(fa+G+1)), 32'hD5);
    chk("a_done2", 32'(done_a[2*fa+G+1]), 32'h1);
    chk("a_no_rdreq", 32'(rdreq_any), 32'h0);
    watch(G + 2);

    // Requester 0, one payload byte, fetch answered one cycle late
    len0 = 8'd1;
    resp_mode = 0;
    resp_byte = 8'h3C;
    fb = (3 + CN) * BC;
    start(2'b01);
    watch(fb + 1);
    req = 2'b00;
    watch(G);
    chk("b_grant", 32'(grant_a[0]), 32'h1);
    chk("b_rdsel", 32'(rdsel_a[0]), 32'h0);
    chk("b_rdreq_sync", 32'(rdreq_a[BC-1]), 32'h0);
    chk("b_rdreq_len0", 32'(rdreq_a[BC]), 32'h1);
    chk("b_rdreq_len1", 32'(rdreq_a[BC+1]), 32'h1);
    chk("b_rdreq_drop", 32'(rdreq_a[BC+2]), 32'h0);
    chk("b_rdreq_last", 32'(rdreq_a[2*BC]), 32'h0);
    chk("b_sync", 32'(dec(0)), 32'hD5);
    chk("b_len", 32'(dec(BC)), 32'h01);
    chk("b_data", 32'(dec(2*BC)), 32'h3C);
`ifdef VLC_CRC8_EN
    chk("b_crc", 32'(dec(3*BC)), 32'(ref_crc(ref_crc(8'h00, 8'h01), 8'h3C)));
`endif
    chk("b_grant_last", 32'(grant_a[fb-1]), 32'h1);
    chk("b_done_early", 32'(done_a[fb-1]), 32'h0);
    chk("b_done", 32'(done_a[fb]), 32'h1);
    chk("b_grant_end", 32'(grant_a[fb]), 32'h0);
    chk("b_led_end", 32'(led_a[fb]), 32'h0);
    chk("b_busy_gap", 32'(busy_a[fb+G-1]), 32'h1);
    chk("b_busy_idle", 32'(busy_a[fb+G]), 32'h0);
    chk("b_no_err", 32'(err_any), 32'h0);
    watch(2);

    // Tie after requester 0 served goes to 1; reset mid-payload
    len0 = 8'd5;
    len1 = 8'd1;
    resp_byte = 8'h77;
    start(2'b11);
    watch(2*BC + 6);
    chk("c_grant", 32'(grant_a[0]), 32'h2);
    chk("c_rdsel", 32'(rdsel_a[0]), 32'h1);
    chk("c_len_latched", 32'(dec(BC)), 32'h01);
    chk("c_busy", 32'(busy_a[2*BC+5]), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("c_async_reset", 32'({grant, rd_req, rd_sel, led_out, busy, done, err}), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    len0 = 8'd0;
    fa = (2 + CN) * BC;
    start(2'b11);
    watch(fa + 1);
    req = 2'b00;
    chk("c_grant_after_rst", 32'(grant_a[0]), 32'h1);
    chk("c_done", 32'(done_a[fa]), 32'h1);
    watch(G + 2);

    // Underrun: fetch never answered
    len0 = 8'd2;
    resp_mode = 1;
    start(2'b01);
    watch(2*BC + 2);
    req = 2'b00;
    chk("d_rdreq_first", 32'(rdreq_a[BC]), 32'h1);
    chk("d_rdreq_held", 32'(rdreq_a[2*BC-1]), 32'h1);
    chk("d_len", 32'(dec(BC)), 32'h02);
    chk("d_err_early", 32'(err_a[2*BC-1]), 32'h0);
    chk("d_err", 32'(err_a[2*BC]), 32'h1);
    chk("d_done", 32'(done_a[2*BC]), 32'h1);
    chk("d_grant", 32'(grant_a[2*BC]), 32'h0);
    chk("d_led", 32'(led_a[2*BC]), 32'h0);
    chk("d_rdreq_drop", 32'(rdreq_a[2*BC]), 32'h0);
    chk("d_err_pulse", 32'(err_a[2*BC+1]), 32'h0);
    watch(G + 2);

    // Two payload bytes, fetch answered in the same cycle
    resp_mode = 2;
    resp_byte = 8'hA5;
    fb = (4 + CN) * BC;
    start(2'b01);
    watch(fb + 1);
    req = 2'b00;
    chk("e_rdreq_len", 32'(rdreq_a[BC]), 32'h1);
    chk("e_rdreq_len_drop", 32'(rdreq_a[BC+1]), 32'h0);
    chk("e_rdreq_d0", 32'(rdreq_a[2*BC]), 32'h1);
    chk("e_rdreq_d0_drop", 32'(rdreq_a[2*BC+1]), 32'h0);
    chk("e_rdreq_last", 32'(rdreq_a[3*BC]), 32'h0);
    chk("e_len", 32'(dec(BC)), 32'h02);
    chk("e_d0", 32'(dec(2*BC)), 32'hA5);
    chk("e_d1", 32'(dec(3*BC)), 32'hA5);
`ifdef VLC_CRC8_EN
    chk("e_crc", 32'(dec(4*BC)), 32'(ref_crc(ref_crc(ref_crc(8'h00, 8'h02), 8'hA5), 8'hA5)));
`endif
    chk("e_done", 32'(done_a[fb]), 32'h1);
    chk("e_no_err", 32'(err_any), 32'h0);
    watch(G + 2);

`ifdef VLC_CRC8_EN
    // CRC frame: D5,01,00,15
    len0 = 8'd1;
    resp_mode = 0;
    resp_byte = 8'h00;
    start(2'b01);
    watch(4*BC + 1);
    req = 2'b00;
    chk("f_len", 32'(dec(BC)), 32'h01);
    chk("f_data", 32'(dec(2*BC)), 32'h00);
    chk("f_crc", 32'(dec(3*BC)), 32'h15);
    chk("f_done", 32'(done_a[4*BC]), 32'h1);
    watch(G + 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
